fir_sample_sequencer: RTL and testbench

FIR_SAMPLE_SEQUENCER -- requirements
Module: fir_sample_sequencer

---
 rtl/fir_sample_sequencer_pkg.sv | 21 ++
 rtl/fir_sample_sequencer_if.sv | 32 +++
 rtl/fir_timeout_cnt.sv | 22 ++
 rtl/fir_sample_sequencer.sv | 83 ++++++++
 tb/tb_fir_sample_sequencer.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/fir_sample_sequencer_pkg.sv
// fir_pkg: shared state encoding, error codes and widths for the FIR sample sequencer
// Contents: fir_seq_state_t (sequencer states), ERR_* (err_code values),
//           FIR_ADDR_W (sample address width), ILE_W (sample count width)
package fir_pkg;
  localparam int FIR_ADDR_W = 13;
  localparam int ILE_W = FIR_ADDR_W + 1;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_RUN,
    S_WAIT,
    S_STEP,
    S_CHECK,
    S_FINISH
  } fir_seq_state_t;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_ABORT = 2'd3;
endpackage

// File: rtl/fir_sample_sequencer_if.sv
// fir_sample_sequencer_if: job control, sample counter and FIR core signals of the sequencer
// Job:     start, abort, ile_probek_in (N) -> busy, done, error, err_code
// Counter: ile_probek, FSM_zapisz_probki, FSM_reset_licznik, FSM_nowa_probka -> licznik_full
// FIR:     fir_start -> fir_done
// slave is the sequencer side, master the side that drives jobs and hosts counter/FIR.
interface fir_sample_sequencer_if;
  import fir_pkg::*;
  logic start;
  logic abort;
  logic [ILE_W-1:0] ile_probek_in;
  logic licznik_full;
  logic fir_done;
  logic [ILE_W-1:0] ile_probek;
  logic FSM_zapisz_probki;
  logic FSM_reset_licznik;
  logic FSM_nowa_probka;
  logic fir_start;
  logic busy;
  logic done;
  logic error;
  logic [1:0] err_code;
  modport master (
    output start, abort, ile_probek_in, licznik_full, fir_done,
    input ile_probek, FSM_zapisz_probki, FSM_reset_licznik, FSM_nowa_probka,
    input fir_start, busy, done, error, err_code
  );
  modport slave (
    input start, abort, ile_probek_in, licznik_full, fir_done,
    output ile_probek, FSM_zapisz_probki, FSM_reset_licznik, FSM_nowa_probka,
    output fir_start, busy, done, error, err_code
  );
endinterface

// File: rtl/fir_timeout_cnt.sv
// fir_timeout_cnt: counts cycles spent waiting for the FIR core and flags the last allowed one
// clk_b, rst_n : clock, asynchronous active-low reset
// i_clr        : restart the count from zero
// i_en         : count one waiting cycle
// o_expired    : the current waiting cycle is number TIMEOUT_CYCLES
module fir_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_b,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk_b or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else r_cnt <= i_clr ? '0 : (i_en && !o_expired) ? r_cnt + 1'b1 : r_cnt;
  // the count starts at zero in the first waiting cycle, so TIMEOUT_CYCLES-1 marks the last one
  assign o_expired = r_cnt == W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/fir_sample_sequencer.sv
// fir_sample_sequencer: steps the FIR core through N samples, driving the sample counter
// clk_b : clock, rising edge
// rst_n : asynchronous active-low reset
// bus   : fir_sample_sequencer_if.slave
//   in : start, abort, ile_probek_in (N), licznik_full, fir_done
//   out: ile_probek (N-1 in LOAD), FSM_zapisz_probki, FSM_reset_licznik, FSM_nowa_probka,
//        fir_start, busy, done, error (sticky), err_code
module fir_sample_sequencer
  import fir_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W = FIR_ADDR_W
) (
  input logic clk_b,
  input logic rst_n,
  fir_sample_sequencer_if.slave bus
);
  localparam logic [31:0] MAX_N = 32'(2 ** ADDR_W);
  fir_seq_state_t r_state;
  fir_seq_state_t w_next;
  logic [ILE_W-1:0] r_limit;
  logic r_error;
  logic [1:0] r_err_code;
  logic w_idle;
  logic w_len_ok;
  logic w_abort;
  logic w_expired;
  logic w_timeout;
  assign w_idle = r_state == S_IDLE;
  assign w_len_ok = bus.ile_probek_in != '0 && 32'(bus.ile_probek_in) <= MAX_N;
  assign w_abort = !w_idle && bus.abort;
  // a fir_done in the last allowed waiting cycle still counts as success
  assign w_timeout = r_state == S_WAIT && !bus.fir_done && w_expired;
  fir_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk_b(clk_b),
    .rst_n(rst_n),
    .i_clr(r_state == S_RUN),
    .i_en(r_state == S_WAIT),
    .o_expired(w_expired)
  );
  always_ff @(posedge clk_b or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  // licznik_full is looked at only in CHECK, so a stale flag cannot end a job early
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = bus.start && w_len_ok ? S_LOAD : S_IDLE;
      S_LOAD:  w_next = S_CLEAR;
      S_CLEAR: w_next = S_RUN;
      S_RUN:   w_next = S_WAIT;
      S_WAIT:  w_next = bus.fir_done ? S_STEP : w_expired ? S_IDLE : S_WAIT;
      S_STEP:  w_next = S_CHECK;
      S_CHECK: w_next = bus.licznik_full ? S_FINISH : S_RUN;
      default: w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end
  always_ff @(posedge clk_b or negedge rst_n)
    if (!rst_n) begin
      r_limit <= '0;
      r_error <= 1'b0;
      r_err_code <= ERR_NONE;
    end else if (w_idle && bus.start) begin
      r_limit <= w_len_ok ? bus.ile_probek_in - ILE_W'(1) : r_limit;
      r_error <= !w_len_ok;
      r_err_code <= w_len_ok ? ERR_NONE : ERR_LEN;
    end else if (w_abort || w_timeout) begin
      r_error <= 1'b1;
      r_err_code <= w_abort ? ERR_ABORT : ERR_TIMEOUT;
    end
  always_comb begin
    bus.busy = !w_idle;
    bus.FSM_zapisz_probki = r_state == S_LOAD;
    bus.FSM_reset_licznik = r_state == S_CLEAR;
    bus.fir_start = r_state == S_RUN;
    bus.FSM_nowa_probka = r_state == S_STEP;
    bus.done = r_state == S_FINISH;
    bus.ile_probek = r_state == S_LOAD ? r_limit : '0;
    bus.error = r_error;
    bus.err_code = r_err_code;
  end
endmodule

// File: tb/tb_fir_sample_sequencer.sv
// tb_fir_sample_sequencer: randomized job scenarios checked against a cycle-count model of the sequencer
module tb_fir_sample_sequencer;
  import fir_pkg::*;
  localparam int TO = 8;
  logic clk_b = 1'b0;
  logic rst_n = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  fir_sample_sequencer_if bus();
  fir_sample_sequencer #(.TIMEOUT_CYCLES(TO), .ADDR_W(13)) dut (
    .clk_b(clk_b),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk_b = ~clk_b;
  // results of the last job; edges are counted from the edge that accepted start
  int j_done_edge, j_end_edge, j_starts, j_steps, j_dones, j_ile, j_cmd_bad, j_err0;
  bit j_acc;
  // sample counter model: samples taken since the last counter reset versus the captured limit
  int m_cnt = 0;
  int m_limit = 0;
  bit p_zap = 0, p_rst = 0, p_nowa = 0;
  int p_ile = 0;

  task automatic run_job(input int n, input int tfir, input int abort_smp, input bit stale, input bit start_noise);
    int cd = 0;
    int k = 0;
    int budget;
    bit z, r, s, st, dn, bz;
    budget = 40 + n * (4 + TO);
    j_done_edge = -1; j_end_edge = -1; j_starts = 0; j_steps = 0; j_dones = 0;
    j_ile = -1; j_cmd_bad = 0;
    p_zap = 0; p_rst = 0; p_nowa = 0;
    bus.start = 1'b1;
    bus.ile_probek_in = 14'(n);
    @(posedge clk_b); #1;
    bus.start = 1'b0;
    j_acc = bus.busy && bus.FSM_zapisz_probki;
    j_err0 = int'(bus.error);
    while (k <= budget) begin
      if (p_zap) m_limit = p_ile;
      if (p_rst) m_cnt = 0;
      if (p_nowa) m_cnt++;
      bus.licznik_full = p_nowa ? (m_cnt >= m_limit + 1) : (stale | 1'($urandom_range(0, 1)));
      z = bus.FSM_zapisz_probki; r = bus.FSM_reset_licznik; s = bus.FSM_nowa_probka;
      st = bus.fir_start; dn = bus.done; bz = bus.busy;
      if (int'(z) + int'(r) + int'(s) > 1 || (z && p_zap) || (r && p_rst) || (s && p_nowa)) j_cmd_bad++;
      if (z) j_ile = int'(bus.ile_probek);
      if (st) j_starts++;
      if (s) j_steps++;
      if (dn) begin
        j_dones++;
        if (j_done_edge < 0) j_done_edge = k;
      end
      p_zap = z; p_rst = r; p_nowa = s; p_ile = int'(bus.ile_probek);
      if (!bz) begin
        j_end_edge = k;
        break;
      end
      bus.abort = 1'b0;
      if (st) begin
        cd = tfir < 0 ? 0 : tfir + 1;
        bus.fir_done = 1'($urandom_range(0, 1));
      end else if (cd > 0) begin
        cd--;
        bus.fir_done = cd == 0;
        bus.abort = cd == 0 && j_starts - 1 == abort_smp;
      end else bus.fir_done = 1'b0;
      bus.start = start_noise && !dn;
      bus.ile_probek_in = (start_noise && !dn) ? 14'd0 : 14'(n);
      @(posedge clk_b); #1;
      k++;
    end
    bus.abort = 1'b0;
    bus.fir_done = 1'b0;
    bus.start = 1'b0;
    p_zap = 0; p_rst = 0; p_nowa = 0;
  endtask

  task automatic test_reset();
    bus.start = 0; bus.abort = 0; bus.ile_probek_in = 0; bus.licznik_full = 0; bus.fir_done = 0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk_b);
    #1;
    n_cmp++;
    if ({bus.busy, bus.done, bus.error, bus.fir_start, bus.FSM_zapisz_probki, bus.FSM_reset_licznik, bus.FSM_nowa_probka} !== 7'b0) begin
      n_bad++; $display("FAIL reset_flags got %b want 0000000", {bus.busy, bus.done, bus.error, bus.fir_start, bus.FSM_zapisz_probki, bus.FSM_reset_licznik, bus.FSM_nowa_probka});
    end
    n_cmp++;
    if (bus.ile_probek !== 14'd0 || bus.err_code !== 2'd0) begin
      n_bad++; $display("FAIL reset_values got ile=%0d code=%0d want 0 0", bus.ile_probek, bus.err_code);
    end
    @(negedge clk_b);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_job(4, 3, -1, 0, 0);
    n_cmp++; if (!j_acc) begin n_bad++; $display("FAIL basic_first_start got 0 want 1"); end
    n_cmp++; if (j_ile !== 3) begin n_bad++; $display("FAIL basic_ile got %0d want 3", j_ile); end
    n_cmp++; if (j_starts !== 4) begin n_bad++; $display("FAIL basic_fir_start got %0d want 4", j_starts); end
    n_cmp++; if (j_steps !== 4) begin n_bad++; $display("FAIL basic_steps got %0d want 4", j_steps); end
    n_cmp++; if (j_done_edge !== 30) begin n_bad++; $display("FAIL basic_latency got %0d want 30", j_done_edge); end
    n_cmp++; if (j_dones !== 1 || j_end_edge !== 31) begin n_bad++; $display("FAIL basic_done got %0d/%0d want 1/31", j_dones, j_end_edge); end
    n_cmp++; if (bus.error !== 1'b0) begin n_bad++; $display("FAIL basic_error got %0d want 0", bus.error); end
    n_cmp++; if (j_cmd_bad !== 0) begin n_bad++; $display("FAIL basic_cmd_overlap got %0d want 0", j_cmd_bad); end
  endtask

  task automatic test_stale_full();
    int t;
    for (int n = 1; n <= 3; n += 2) begin
      t = $urandom_range(0, 4);
      run_job(n, t, -1, 1, 0);
      n_cmp++; if (j_starts !== n) begin n_bad++; $display("FAIL stale_fir_start n=%0d got %0d want %0d", n, j_starts, n); end
      n_cmp++; if (j_steps !== n) begin n_bad++; $display("FAIL stale_steps n=%0d got %0d want %0d", n, j_steps, n); end
      n_cmp++; if (j_done_edge !== 2 + n * (4 + t)) begin n_bad++; $display("FAIL stale_latency n=%0d got %0d want %0d", n, j_done_edge, 2 + n * (4 + t)); end
    end
  endtask

  task automatic test_bad_length();
    int lens[3] = '{0, 8193, 16383};
    int t;
    foreach (lens[i]) begin
      bus.start = 1'b1;
      bus.ile_probek_in = 14'(lens[i]);
      @(posedge clk_b); #1;
      bus.start = 1'b0;
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL badlen_busy n=%0d got %0d want 0", lens[i], bus.busy); end
      @(posedge clk_b); #1;
      n_cmp++;
      if (bus.error !== 1'b1 || bus.err_code !== ERR_LEN) begin
        n_bad++; $display("FAIL badlen_error n=%0d got %0d/%0d want 1/1", lens[i], bus.error, bus.err_code);
      end
    end
    t = $urandom_range(0, 5);
    run_job(2, t, -1, 0, 0);
    n_cmp++; if (j_err0 !== 0) begin n_bad++; $display("FAIL badlen_clear got %0d want 0", j_err0); end
    n_cmp++; if (j_done_edge !== 2 + 2 * (4 + t)) begin n_bad++; $display("FAIL badlen_recover got %0d want %0d", j_done_edge, 2 + 2 * (4 + t)); end
    n_cmp++; if (bus.err_code !== ERR_NONE) begin n_bad++; $display("FAIL badlen_code_after got %0d want 0", bus.err_code); end
  endtask

  task automatic test_random_jobs();
    int n, t;
    for (int i = 0; i < 7; i++) begin
      n = $urandom_range(1, 12);
      t = i == 0 ? TO - 1 : $urandom_range(0, TO - 1);
      run_job(n, t, -1, 0, 1);
      n_cmp++; if (j_starts !== n || j_steps !== n) begin n_bad++; $display("FAIL rand_counts n=%0d got %0d/%0d want %0d", n, j_starts, j_steps, n); end
      n_cmp++; if (j_ile !== n - 1) begin n_bad++; $display("FAIL rand_ile got %0d want %0d", j_ile, n - 1); end
      n_cmp++; if (j_done_edge !== 2 + n * (4 + t) || j_dones !== 1) begin n_bad++; $display("FAIL rand_done n=%0d t=%0d got %0d x%0d want %0d", n, t, j_done_edge, j_dones, 2 + n * (4 + t)); end
      n_cmp++; if (bus.error !== 1'b0 || j_cmd_bad !== 0) begin n_bad++; $display("FAIL rand_clean got err=%0d bad=%0d want 0 0", bus.error, j_cmd_bad); end
    end
  endtask

  task automatic test_timeout();
    run_job($urandom_range(2, 5), -1, -1, 0, 0);
    n_cmp++; if (j_end_edge !== 3 + TO) begin n_bad++; $display("FAIL timeout_edge got %0d want %0d", j_end_edge, 3 + TO); end
    n_cmp++; if (j_steps !== 0 || j_starts !== 1 || j_dones !== 0) begin n_bad++; $display("FAIL timeout_pulses got %0d/%0d/%0d want 0/1/0", j_steps, j_starts, j_dones); end
    n_cmp++; if (bus.error !== 1'b1 || bus.err_code !== ERR_TIMEOUT) begin n_bad++; $display("FAIL timeout_error got %0d/%0d want 1/2", bus.error, bus.err_code); end
  endtask

  task automatic test_abort();
    int t;
    t = $urandom_range(0, 3);
    run_job(4, t, 1, 0, 0);
    n_cmp++; if (j_end_edge !== 2 + (4 + t) + t + 2) begin n_bad++; $display("FAIL abort_edge got %0d want %0d", j_end_edge, 2 + (4 + t) + t + 2); end
    n_cmp++; if (j_steps !== 1 || j_starts !== 2 || j_dones !== 0) begin n_bad++; $display("FAIL abort_pulses got %0d/%0d/%0d want 1/2/0", j_steps, j_starts, j_dones); end
    n_cmp++; if (bus.error !== 1'b1 || bus.err_code !== ERR_ABORT) begin n_bad++; $display("FAIL abort_error got %0d/%0d want 1/3", bus.error, bus.err_code); end
    bus.start = 1'b1;
    bus.ile_probek_in = 14'd5;
    @(posedge clk_b); #1;
    bus.start = 1'b0;
    bus.abort = 1'b1;
    @(posedge clk_b); #1;
    bus.abort = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.FSM_reset_licznik !== 1'b0 || bus.err_code !== ERR_ABORT || bus.error !== 1'b1) begin
      n_bad++; $display("FAIL abort_load got busy=%0d clr=%0d err=%0d code=%0d want 0 0 1 3", bus.busy, bus.FSM_reset_licznik, bus.error, bus.err_code);
    end
  endtask

  task automatic test_reset_mid_job();
    int seen = 0;
    bus.start = 1'b1;
    bus.ile_probek_in = 14'd6;
    @(posedge clk_b); #1;
    bus.start = 1'b0;
    bus.fir_done = 1'b0;
    repeat (3) @(posedge clk_b);
    #1;
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_before got %0d want 1", bus.busy); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.busy, bus.done, bus.error, bus.fir_start, bus.FSM_zapisz_probki, bus.FSM_reset_licznik, bus.FSM_nowa_probka} !== 7'b0
        || bus.ile_probek !== 14'd0 || bus.err_code !== 2'd0) begin
      n_bad++; $display("FAIL rstmid_outputs got busy=%0d err=%0d code=%0d want all 0", bus.busy, bus.error, bus.err_code);
    end
    @(negedge clk_b);
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk_b); #1;
      if (bus.done || bus.error || bus.busy) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rstmid_after got %0d active cycles want 0", seen); end
  endtask

  task automatic test_full_length();
    run_job(8192, 0, -1, 0, 0);
    n_cmp++; if (j_steps !== 8192 || j_starts !== 8192) begin n_bad++; $display("FAIL full_counts got %0d/%0d want 8192", j_steps, j_starts); end
    n_cmp++; if (j_ile !== 8191) begin n_bad++; $display("FAIL full_ile got %0d want 8191", j_ile); end
    n_cmp++; if (j_dones !== 1 || j_done_edge !== 2 + 8192 * 4) begin n_bad++; $display("FAIL full_done got %0d x%0d want %0d x1", j_done_edge, j_dones, 2 + 8192 * 4); end
    n_cmp++; if (j_cmd_bad !== 0) begin n_bad++; $display("FAIL full_cmd_overlap got %0d want 0", j_cmd_bad); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_stale_full();
    test_bad_length();
    test_random_jobs();
    test_timeout();
    test_abort();
    test_reset_mid_job();
    test_full_length();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
